// File: rtl/fifo_word_packer.sv
// Drains bytes from an 8-bit FIFO read port and packs them LSB-lane first into
// words offered on a valid/ready interface; FLUSH emits a partial word with its byte count.
module fifo_word_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int CNT_W          = $clog2(BYTES_PER_WORD + 1)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        FIFO_EMPTY,
  input  logic [7:0]                  FIFO_DOUT,
  output logic                        FIFO_RD_EN,
  input  logic                        FLUSH,
  output logic [8*BYTES_PER_WORD-1:0] WORD_OUT,
  output logic [CNT_W-1:0]            WORD_BYTES,
  output logic                        WORD_VALID,
  input  logic                        WORD_READY,
  output logic                        DBG_STATE
);

  localparam int             W    = 8 * BYTES_PER_WORD;
  localparam logic [CNT_W:0] FULL = (CNT_W + 1)'(BYTES_PER_WORD);

  // Word handshake: a word transfers on each rising edge where WORD_VALID and
  // WORD_READY are both high; WORD_OUT/WORD_BYTES hold steady while VALID waits for READY.
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t         state;
  logic [CNT_W-1:0] cnt;
  logic           pend;
  logic           flush_req;
  logic [W-1:0]   asm_q;
  logic [W-1:0]   asm_next;
  logic [CNT_W:0] level;
  logic [CNT_W:0] cnt_inc;

  // Bytes already held plus the one in flight must leave room for another read.
  assign level      = {1'b0, cnt} + {{CNT_W{1'b0}}, pend};
  assign cnt_inc    = {1'b0, cnt} + (CNT_W + 1)'(1);
  assign FIFO_RD_EN = !RST && (state == FILL) && !FIFO_EMPTY && !flush_req && (level < FULL);
  assign DBG_STATE  = state;

  always_comb begin
    asm_next = asm_q;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (pend && (cnt == CNT_W'(k))) asm_next[8*k +: 8] = FIFO_DOUT;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= FILL;
      cnt        <= '0;
      pend       <= 1'b0;
      flush_req  <= 1'b0;
      asm_q      <= '0;
      WORD_OUT   <= '0;
      WORD_BYTES <= '0;
      WORD_VALID <= 1'b0;
    end else begin
      pend <= FIFO_RD_EN;
      case (state)
        FILL: begin
          if (pend) begin
            if (cnt_inc == FULL) begin
              WORD_OUT   <= asm_next;
              WORD_BYTES <= CNT_W'(BYTES_PER_WORD);
              WORD_VALID <= 1'b1;
              state      <= HOLD;
              cnt        <= '0;
              asm_q      <= '0;
              flush_req  <= 1'b0;
            end else begin
              cnt   <= cnt_inc[CNT_W-1:0];
              asm_q <= asm_next;
              if (FLUSH) flush_req <= 1'b1;
            end
          end else if (flush_req) begin
            // Nothing in flight: emit whatever is assembled, or just drop the request.
            flush_req <= 1'b0;
            if (cnt != '0) begin
              WORD_OUT   <= asm_q;
              WORD_BYTES <= cnt;
              WORD_VALID <= 1'b1;
              state      <= HOLD;
              cnt        <= '0;
              asm_q      <= '0;
            end
          end else if (FLUSH) begin
            flush_req <= 1'b1;
          end
        end
        HOLD: begin
          if (WORD_READY) begin
            WORD_VALID <= 1'b0;
            state      <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: a queue-backed FIFO feeds the DUT; expected words are
// formed from the written byte stream in groups of four, with flushes cutting partial words.
module tb_fifo_word_packer;

  localparam int BPW = 4;
  localparam int CW  = 3;
  localparam int W   = CW + 8 * BPW;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        FIFO_EMPTY = 1'b1;
  logic [7:0]  FIFO_DOUT = 8'h00;
  logic        FIFO_RD_EN;
  logic        FLUSH = 1'b0;
  logic [31:0] WORD_OUT;
  logic [2:0]  WORD_BYTES;
  logic        WORD_VALID;
  logic        WORD_READY = 1'b0;
  logic        DBG_STATE;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_rd_cyc = -100;

  logic [7:0]   fifo_q[$];
  logic [7:0]   stream_q[$];
  logic [W-1:0] exp_q[$];

  fifo_word_packer #(.BYTES_PER_WORD(BPW), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DOUT(FIFO_DOUT),
    .FIFO_RD_EN(FIFO_RD_EN), .FLUSH(FLUSH), .WORD_OUT(WORD_OUT),
    .WORD_BYTES(WORD_BYTES), .WORD_VALID(WORD_VALID), .WORD_READY(WORD_READY),
    .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- FIFO read port ----------------
  always @(posedge CLK) begin
    if (FIFO_RD_EN && fifo_q.size() > 0) FIFO_DOUT <= fifo_q.pop_front();
    #1 FIFO_EMPTY = (fifo_q.size() == 0);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic void form_words();
    logic [31:0] w;
    while (stream_q.size() >= BPW) begin
      w = '0;
      for (int k = 0; k < BPW; k++) w[8*k +: 8] = stream_q.pop_front();
      exp_q.push_back({3'(BPW), w});
    end
  endfunction

  function automatic void model_push(input logic [7:0] b);
    fifo_q.push_back(b);
    stream_q.push_back(b);
    form_words();
  endfunction

  function automatic void model_flush();
    logic [31:0] w;
    int n;
    n = stream_q.size();
    if (n > 0) begin
      w = '0;
      for (int k = 0; k < n; k++) w[8*k +: 8] = stream_q.pop_front();
      exp_q.push_back({3'(n), w});
    end
  endfunction

  // Reset discards offered and partial words; bytes still in the FIFO start afresh.
  function automatic void model_reset();
    exp_q.delete();
    stream_q = fifo_q;
    form_words();
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic         prev_stall = 1'b0;
  logic         prev_valid = 1'b0;
  logic [W-1:0] prev_word  = '0;

  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (FIFO_RD_EN) begin
        last_rd_cyc = cyc;
        check("rd_en_legal", {FIFO_EMPTY, WORD_VALID}, 0);
      end
      if (prev_stall) check("hold_stable", {WORD_VALID, WORD_BYTES, WORD_OUT}, {1'b1, prev_word});
      if (WORD_VALID && !prev_valid && WORD_BYTES == 3'(BPW))
        check("full_word_latency", cyc - last_rd_cyc, 2);
      if (WORD_VALID && WORD_READY) begin
        if (exp_q.size() == 0) check("unexpected_word", WORD_VALID, 0);
        else check("word", {WORD_BYTES, WORD_OUT}, exp_q.pop_front());
      end
      prev_stall = WORD_VALID && !WORD_READY;
      prev_word  = {WORD_BYTES, WORD_OUT};
      prev_valid = WORD_VALID;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && i < limit) begin
      tick(1);
      i++;
    end
    check(tag, exp_q.size(), 0);
    tick(3);
  endtask

  task automatic pulse_flush();
    FLUSH = 1'b1;
    model_flush();
    tick(1);
    FLUSH = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int pushed;
    int guard;
    int vcount;
    int rcount;

    tick(3);
    check("reset_outputs", {WORD_VALID, WORD_BYTES, WORD_OUT, FIFO_RD_EN}, 0);
    RST = 1'b0;
    tick(2);

    // Two back-to-back words with READY held high.
    WORD_READY = 1'b1;
    for (int b = 0; b < 8; b++) model_push(8'(b));
    wait_idle("t1_drain", 200);
    check("t1_fifo_empty", FIFO_EMPTY, 1);

    // Downstream stall: the first word must sit unchanged with no reads.
    WORD_READY = 1'b0;
    for (int b = 16; b < 24; b++) model_push(8'(b));
    tick(20);
    check("t2_held_word", {WORD_VALID, WORD_BYTES, WORD_OUT}, {1'b1, 3'd4, 32'h13121110});
    check("t2_no_read", FIFO_RD_EN, 0);
    WORD_READY = 1'b1;
    wait_idle("t2_drain", 200);

    // Flush of a two-byte partial word, then a full word.
    WORD_READY = 1'b0;
    model_push(8'hA1);
    model_push(8'hA2);
    tick(6);
    pulse_flush();
    tick(4);
    check("t3_partial", {WORD_VALID, WORD_BYTES, WORD_OUT}, {1'b1, 3'd2, 32'h0000A2A1});
    WORD_READY = 1'b1;
    for (int b = 0; b < 4; b++) model_push(8'hB0 + 8'(b));
    wait_idle("t3_drain", 200);

    // Flush with nothing collected produces no word.
    pulse_flush();
    vcount = 0;
    rcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (WORD_VALID) vcount++;
      if (FIFO_RD_EN) rcount++;
      tick(1);
    end
    check("t4_no_word", vcount, 0);
    check("t4_no_read", rcount, 0);

    // Slow producer: reads only while the FIFO has data.
    model_push(8'h11); tick(10);
    model_push(8'h22); tick(10);
    model_push(8'h33); tick(10);
    check("t5_not_yet", WORD_VALID, 0);
    model_push(8'h44); tick(10);
    wait_idle("t5_drain", 200);

    // Reset while a word is offered and more bytes wait in the FIFO.
    WORD_READY = 1'b0;
    for (int b = 0; b < 6; b++) model_push(8'hC0 + 8'(b));
    tick(12);
    check("t6_held_before_rst", {WORD_VALID, WORD_OUT}, {1'b1, 32'hC3C2C1C0});
    RST = 1'b1;
    #1;
    check("t6_async_clear", {WORD_VALID, WORD_BYTES, WORD_OUT, FIFO_RD_EN}, 0);
    model_reset();
    tick(2);
    RST = 1'b0;
    WORD_READY = 1'b1;
    model_push(8'hC6);
    model_push(8'hC7);
    wait_idle("t6_fresh_word", 200);

    // Reset after two bytes captured; the next four bytes form a fresh word.
    model_push(8'hD0);
    model_push(8'hD1);
    tick(6);
    RST = 1'b1;
    #1;
    check("t6b_async_clear", {WORD_VALID, WORD_BYTES, WORD_OUT, FIFO_RD_EN}, 0);
    model_reset();
    tick(2);
    RST = 1'b0;
    for (int b = 2; b < 6; b++) model_push(8'hD0 + 8'(b));
    wait_idle("t6b_drain", 200);

    // Random bytes, random gaps, random backpressure.
    pushed = 0;
    guard  = 0;
    while ((pushed < 64 || exp_q.size() != 0) && guard < 4000) begin
      WORD_READY = ($urandom_range(0, 3) != 0);
      if (pushed < 64 && $urandom_range(0, 2) == 0) begin
        model_push(8'($urandom));
        pushed++;
      end
      tick(1);
      guard++;
    end
    check("rand_drain", exp_q.size(), 0);
    WORD_READY = 1'b1;
    tick(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
